hex_accumulator_display: RTL and testbench

Parametrised successor to the switch-adder/hex-display lab block. It accumulates a switch operand into a registered running total, one step per debounced pushbutton press (add or subtract). It supports wrap or saturate arithmetic with a sticky overflow flag, and drives N active-low seven-segment digits with optional leading-zero blanking. It sits at board top level between SW/KEY and HEXn/LEDR.

---
 rtl/hex_disp_pkg.sv | 28 ++
 rtl/key_debounce.sv | 47 ++++
 rtl/hex_accumulator_display.sv | 129 ++++++++++++
 tb/tb_hex_accumulator_display.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants for the hex accumulator display: seven-segment table,
// blank pattern and the arithmetic/operation encodings.
package hex_disp_pkg;

    // Active-high gfedcba patterns, element n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_HI = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK_N = 7'h7F;

    typedef enum logic {
        ARITH_WRAP = 1'b0,
        ARITH_SAT  = 1'b1
    } arith_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } op_e;

    function automatic logic [6:0] seg_n(input logic [3:0] nib);
        return ~SEG_HI[nib];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low pushbutton; emits a single-cycle
// pulse when the debounced level falls.
module key_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          stable;
    logic [CW-1:0] cnt;

    // A level change is accepted only after the counter has run up while the
    // synced level kept differing; any agreeing cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta        <= 1'b1;
            sync        <= 1'b1;
            stable      <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            meta        <= key_n;
            sync        <= meta;
            press_pulse <= 1'b0;
            if (sync != stable) begin
                if (cnt == CNT_MAX) begin
                    stable      <= sync;
                    cnt         <= '0;
                    press_pulse <= ~sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hex_accumulator_display.sv
// Running add/subtract accumulator driven by debounced keys, with wrap or
// saturate arithmetic, sticky overflow and active-low hex digit outputs.
module hex_accumulator_display
    import hex_disp_pkg::*;
#(
    parameter int IN_W       = 5,
    parameter int ACC_W      = 16,
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 1000000,
    parameter int BLANK_LZ   = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic [IN_W-1:0]       SW_OP,
    input  logic                  KEY_ADD_N,
    input  logic                  KEY_SUB_N,
    input  logic                  MODE_SAT,
    input  logic                  CLEAR,
    output logic [7*DIGITS-1:0]   HEX_N,
    output logic [ACC_W-1:0]      ACC,
    output logic                  OVF
);

    localparam int PAD_W = 4 * DIGITS;

    logic             add_ev;
    logic             sub_ev;
    logic             clr_meta;
    logic             clr_sync;
    op_e              op;
    logic [ACC_W:0]   opnd_x;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   diff;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_nxt;
    logic [PAD_W-1:0] acc_pad;
    logic [7*DIGITS-1:0] hex_nxt;
    logic [7*DIGITS-1:0] hex_rst;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_add_key (
        .clk         (CLOCK_50),
        .rst         (RESET),
        .key_n       (KEY_ADD_N),
        .press_pulse (add_ev)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sub_key (
        .clk         (CLOCK_50),
        .rst         (RESET),
        .key_n       (KEY_SUB_N),
        .press_pulse (sub_ev)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            clr_meta <= 1'b0;
            clr_sync <= 1'b0;
        end else begin
            clr_meta <= CLEAR;
            clr_sync <= clr_meta;
        end
    end

    // Coincident add and sub events cancel each other.
    always_comb begin
        op = OP_NONE;
        if (add_ev && !sub_ev)
            op = OP_ADD;
        else if (sub_ev && !add_ev)
            op = OP_SUB;
    end

    always_comb begin
        opnd_x  = (ACC_W + 1)'(SW_OP);
        sum     = {1'b0, ACC} + opnd_x;
        diff    = {1'b0, ACC} - opnd_x;
        acc_nxt = ACC;
        ovf_nxt = OVF;
        case (op)
            OP_ADD: begin
                ovf_nxt = OVF | sum[ACC_W];
                acc_nxt = (sum[ACC_W] && MODE_SAT == ARITH_SAT) ? '1 : sum[ACC_W-1:0];
            end
            OP_SUB: begin
                ovf_nxt = OVF | diff[ACC_W];
                acc_nxt = (diff[ACC_W] && MODE_SAT == ARITH_SAT) ? '0 : diff[ACC_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            ACC <= '0;
            OVF <= 1'b0;
        end else if (clr_sync) begin
            ACC <= '0;
            OVF <= 1'b0;
        end else begin
            ACC <= acc_nxt;
            OVF <= ovf_nxt;
        end
    end

    assign acc_pad = PAD_W'(ACC);

    // Digit k blanks only when it and every higher nibble are zero.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] nib;
        logic       blank;
        assign nib = acc_pad[4*k +: 4];
        if (BLANK_LZ != 0 && k > 0) begin : g_lz
            assign blank = (acc_pad[PAD_W-1:4*k] == '0);
            assign hex_rst[7*k +: 7] = SEG_BLANK_N;
        end else begin : g_nolz
            assign blank = 1'b0;
            assign hex_rst[7*k +: 7] = seg_n(4'h0);
        end
        assign hex_nxt[7*k +: 7] = blank ? SEG_BLANK_N : seg_n(nib);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET)
            HEX_N <= hex_rst;
        else
            HEX_N <= hex_nxt;
    end

endmodule

// File: tb/tb_hex_accumulator_display.sv
// Directed bench for hex_accumulator_display: a 16-bit four-digit instance and
// an 8-bit two-digit instance with leading-zero blanking, both DEB_CYCLES=4.
module tb_hex_accumulator_display;

    localparam int DEB = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic [4:0]  sw   = '0;
    logic        kadd = 1'b1;
    logic        ksub = 1'b1;
    logic        msat = 1'b0;
    logic        clr  = 1'b0;
    logic [27:0] hex;
    logic [15:0] acc;
    logic        ovf;

    hex_accumulator_display #(
        .IN_W(5), .ACC_W(16), .DIGITS(4), .DEB_CYCLES(DEB), .BLANK_LZ(0)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .SW_OP    (sw),
        .KEY_ADD_N(kadd),
        .KEY_SUB_N(ksub),
        .MODE_SAT (msat),
        .CLEAR    (clr),
        .HEX_N    (hex),
        .ACC      (acc),
        .OVF      (ovf)
    );

    // ---------------- 8-bit instance ----------------
    logic [4:0]  sw8   = '0;
    logic        kadd8 = 1'b1;
    logic        ksub8 = 1'b1;
    logic        msat8 = 1'b0;
    logic        clr8  = 1'b0;
    logic [13:0] hex8;
    logic [7:0]  acc8;
    logic        ovf8;

    hex_accumulator_display #(
        .IN_W(5), .ACC_W(8), .DIGITS(2), .DEB_CYCLES(DEB), .BLANK_LZ(1)
    ) dut8 (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .SW_OP    (sw8),
        .KEY_ADD_N(kadd8),
        .KEY_SUB_N(ksub8),
        .MODE_SAT (msat8),
        .CLEAR    (clr8),
        .HEX_N    (hex8),
        .ACC      (acc8),
        .OVF      (ovf8)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_acc(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed empty-queue expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {16'h0, acc}, {16'h0, e});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 main add, 1 main sub, 2 main add+sub together, 3 dut8 add
    task automatic press(input int which);
        case (which)
            0: kadd = 1'b0;
            1: ksub = 1'b0;
            2: begin kadd = 1'b0; ksub = 1'b0; end
            default: kadd8 = 1'b0;
        endcase
        wait_neg(DEB + 6);
        kadd = 1'b1; ksub = 1'b1; kadd8 = 1'b1;
        wait_neg(DEB + 6);
    endtask

    task automatic do_clear(input bit on8);
        if (on8) clr8 = 1'b1; else clr = 1'b1;
        wait_neg(4);
        clr = 1'b0; clr8 = 1'b0;
        wait_neg(4);
    endtask

    task automatic load_f0;
        sw8 = 5'd31;
        for (int i = 0; i < 7; i++) press(3);
        sw8 = 5'd23;
        press(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // 1: reset state
        wait_neg(3);
        check("rst_acc", {16'h0, acc}, 32'h0);
        check("rst_ovf", {31'h0, ovf}, 32'h0);
        check("rst_hex", {4'h0, hex}, {4'h0, {4{7'h40}}});
        check("rst_acc8", {24'h0, acc8}, 32'h0);
        check("rst_hex8", {18'h0, hex8}, {18'h0, 7'h7F, 7'h40});
        rst = 1'b0;
        wait_neg(2);

        // 2: three adds of 31
        sw = 5'd31;
        exp_q.push_back(16'd31); press(0); check_acc("add1");
        exp_q.push_back(16'd62); press(0); check_acc("add2");
        exp_q.push_back(16'h005D); press(0); check_acc("add3");
        check("add3_hex", {4'h0, hex}, {4'h0, 7'h40, 7'h40, 7'h12, 7'h21});
        check("add3_ovf", {31'h0, ovf}, 32'h0);

        // 3: bouncing key yields one event
        do_clear(1'b0);
        check("clr_acc", {16'h0, acc}, 32'h0);
        sw = 5'd1;
        for (int i = 0; i < 6; i++) begin
            kadd = i[0];
            wait_neg(2);
        end
        check("bounce_none", {16'h0, acc}, 32'h0);
        kadd = 1'b0;
        wait_neg(20);
        kadd = 1'b1;
        wait_neg(DEB + 6);
        check("bounce_one", {16'h0, acc}, 32'h1);

        // 4: 8-bit wrap then saturate on carry
        load_f0();
        check("w8_f0", {24'h0, acc8}, 32'hF0);
        check("w8_ovf0", {31'h0, ovf8}, 32'h0);
        sw8 = 5'h1F;
        press(3);
        check("wrap_acc", {24'h0, acc8}, 32'h0F);
        check("wrap_ovf", {31'h0, ovf8}, 32'h1);
        check("wrap_hex_lz", {18'h0, hex8}, {18'h0, 7'h7F, 7'h0E});
        do_clear(1'b1);
        check("clr8_acc", {24'h0, acc8}, 32'h0);
        check("clr8_ovf", {31'h0, ovf8}, 32'h0);
        msat8 = 1'b1;
        load_f0();
        sw8 = 5'h1F;
        press(3);
        check("sat_acc", {24'h0, acc8}, 32'hFF);
        check("sat_ovf", {31'h0, ovf8}, 32'h1);
        check("sat_hex", {18'h0, hex8}, {18'h0, 7'h0E, 7'h0E});

        // 5: saturating borrow, clear, simultaneous keys, wrapping borrow
        do_clear(1'b0);
        msat = 1'b1;
        sw = 5'd3;
        exp_q.push_back(16'd3); press(0); check_acc("s_add3");
        sw = 5'd5;
        exp_q.push_back(16'd0); press(1); check_acc("s_sub5");
        check("s_sub_ovf", {31'h0, ovf}, 32'h1);
        do_clear(1'b0);
        check("s_clr_ovf", {31'h0, ovf}, 32'h0);
        sw = 5'd3;
        exp_q.push_back(16'd3); press(0); check_acc("s_add3b");
        exp_q.push_back(16'd3); press(2); check_acc("both_keys");
        check("both_ovf", {31'h0, ovf}, 32'h0);
        msat = 1'b0;
        sw = 5'd5;
        exp_q.push_back(16'hFFFE); press(1); check_acc("w_sub5");
        check("w_sub_ovf", {31'h0, ovf}, 32'h1);
        check("w_sub_hex", {4'h0, hex}, {4'h0, 7'h0E, 7'h0E, 7'h0E, 7'h06});

        // 6: reset during debounce, then fresh debounce latency
        sw = 5'd1;
        kadd = 1'b0;
        wait_neg(4);
        rst = 1'b1;
        #1;
        check("mid_rst_acc", {16'h0, acc}, 32'h0);
        check("mid_rst_ovf", {31'h0, ovf}, 32'h0);
        check("mid_rst_hex", {4'h0, hex}, {4'h0, {4{7'h40}}});
        wait_neg(2);
        rst = 1'b0;
        wait_neg(DEB + 2);
        check("lat_early", {16'h0, acc}, 32'h0);
        wait_neg(1);
        check("lat_acc", {16'h0, acc}, 32'h1);
        check("lat_hex_lag", {4'h0, hex}, {4'h0, {4{7'h40}}});
        wait_neg(1);
        check("lat_hex", {4'h0, hex}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h79});
        wait_neg(20);
        check("held_once", {16'h0, acc}, 32'h1);
        kadd = 1'b1;
        wait_neg(DEB + 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
